clock_time_dec: RTL



---
 rtl/clock_time_dec.sv | 110 +++++++++++
 1 files changed

// File: rtl/clock_time_dec.sv
// BCD time-of-day counter: divides clk down to a 1 Hz second event and keeps
// hours/minutes/seconds in packed BCD {hour[5:0], min[6:0], sec[6:0]}.
// Provides one-cycle second and day-rollover ticks plus a synchronous overwrite.
module clock_time_dec #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        time_ow,
  input  logic [19:0] time_in,
  output logic [19:0] time_out,
  output logic        sec_tick,
  output logic        day_tick
);

  localparam int unsigned PreW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_FREQ - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [19:0]     time_q, time_d;
  logic            sec_tick_q, sec_tick_d;
  logic            day_tick_q, day_tick_d;

  logic [6:0] sec_cur, min_cur, sec_nx, min_nx;
  logic [5:0] hour_cur, hour_nx;
  logic       sec_wrap, min_wrap, hour_wrap;

  assign sec_cur  = time_q[6:0];
  assign min_cur  = time_q[13:7];
  assign hour_cur = time_q[19:14];

  // Limit compares use >= so out-of-range loaded values recover on the next carry.
  assign sec_wrap  = (sec_cur >= 7'h59);
  assign min_wrap  = (min_cur >= 7'h59);
  assign hour_wrap = (hour_cur >= 6'h23);

  // BCD increment of each field, rippling carries upward.
  always_comb begin
    sec_nx  = sec_cur;
    min_nx  = min_cur;
    hour_nx = hour_cur;
    if (sec_wrap) begin
      sec_nx = 7'h00;
    end else if (sec_cur[3:0] >= 4'd9) begin
      sec_nx = {sec_cur[6:4] + 3'd1, 4'h0};
    end else begin
      sec_nx = sec_cur + 7'd1;
    end
    if (sec_wrap) begin
      if (min_wrap) begin
        min_nx = 7'h00;
      end else if (min_cur[3:0] >= 4'd9) begin
        min_nx = {min_cur[6:4] + 3'd1, 4'h0};
      end else begin
        min_nx = min_cur + 7'd1;
      end
    end
    if (sec_wrap && min_wrap) begin
      if (hour_wrap) begin
        hour_nx = 6'h00;
      end else if (hour_cur[3:0] >= 4'd9) begin
        hour_nx = {hour_cur[5:4] + 2'd1, 4'h0};
      end else begin
        hour_nx = hour_cur + 6'd1;
      end
    end
  end

  // Next state: overwrite beats the second event, which beats hold.
  always_comb begin
    pre_d      = pre_q;
    time_d     = time_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;
    if (time_ow) begin
      time_d = time_in;
      pre_d  = '0;
    end else if (en) begin
      if (pre_q == PreMax) begin
        pre_d      = '0;
        time_d     = {hour_nx, min_nx, sec_nx};
        sec_tick_d = 1'b1;
        day_tick_d = sec_wrap & min_wrap & hour_wrap;
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pre_q      <= '0;
      time_q     <= 20'h00000;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      time_q     <= time_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign time_out = time_q;
  assign sec_tick = sec_tick_q;
  assign day_tick = day_tick_q;

endmodule
